e_muldiv_unit: RTL and testbench

- HI/LO multiply/divide unit inside the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu with fixed multi-cycle latency, and mthi/mtlo in a single cycle.
- Drives HILO_out, the mfhi/mflo value that the E/M pipeline register captures as HILO_in for the M stage.
- Exports Start|Busy to the hazard unit so D-stage HI/LO instructions stall until results are final.

---
 rtl/e_muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_e_muldiv_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit : HI/LO multiply/divide unit for the E stage.
//   Runs mult/multu/div/divu with a fixed multi-cycle latency and mthi/mtlo
//   in one cycle. Results land in hidden RES_HI/RES_LO at accept and are
//   committed to HI/LO on the edge where the busy counter reaches zero.
// Ports:
//   Clk, Rst         rising-edge clock, async active-high reset
//   Start, Op        qualified HI/LO op (0 none,1 mult,2 multu,3 div,4 divu,
//                    5 mthi,6 mtlo,7 none)
//   A, B             forwarded rs/rt operands, sampled only at accept
//   RdSel            0 -> HILO_out=HI, 1 -> HILO_out=LO
//   Busy             multi-cycle op in flight
//   HI, LO           architectural registers
//   HILO_out         mfhi/mflo read value, from committed registers only
//   Stall_req        Busy | accepting a mul/div this cycle
module e_muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        RdSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HILO_out,
  output logic        Stall_req
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_res_hi, r_res_lo;
  logic [31:0] w_res_hi, w_res_lo;
  logic        w_accept, w_commit, w_wr_hi, w_wr_lo, w_is_muldiv;

  // ---------------- arithmetic (evaluated on the accept cycle) ----------------
  logic [63:0] w_prod_s, w_prod_u;
  logic        w_sdiv, w_neg_a, w_neg_b, w_b_zero;
  logic [31:0] w_dvd, w_dvs, w_dvs_safe, w_q, w_r, w_q_out, w_r_out;

  // Sign-extend to 64 bits; the low 64 bits of the unsigned product equal
  // the two's-complement signed product.
  assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide done on magnitudes; -2^31 / -1 falls out naturally as
  // quotient 0x8000_0000 remainder 0.
  assign w_sdiv     = (Op == 3'd3);
  assign w_neg_a    = w_sdiv & A[31];
  assign w_neg_b    = w_sdiv & B[31];
  assign w_dvd      = w_neg_a ? (~A + 32'd1) : A;
  assign w_dvs      = w_neg_b ? (~B + 32'd1) : B;
  assign w_b_zero   = (B == 32'd0);
  assign w_dvs_safe = w_b_zero ? 32'd1 : w_dvs;
  assign w_q        = w_dvd / w_dvs_safe;
  assign w_r        = w_dvd % w_dvs_safe;
  assign w_q_out    = (w_neg_a ^ w_neg_b) ? (~w_q + 32'd1) : w_q;
  assign w_r_out    = w_neg_a ? (~w_r + 32'd1) : w_r;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (Op)
      3'd1: begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
      3'd2: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
      3'd3, 3'd4: begin
        if (w_b_zero) begin
          w_res_hi = A;
          w_res_lo = 32'hFFFF_FFFF;
        end else begin
          w_res_hi = w_r_out;
          w_res_lo = w_q_out;
        end
      end
      default: ;
    endcase
  end

  // ---------------- control FSM ----------------
  assign w_is_muldiv = (Op >= 3'd1) && (Op <= 3'd4);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          case (Op)
            3'd1, 3'd2: begin w_accept = 1'b1; w_cnt_nxt = 4'(MULT_CYCLES); end
            3'd3, 3'd4: begin w_accept = 1'b1; w_cnt_nxt = 4'(DIV_CYCLES);  end
            3'd5:       w_wr_hi = 1'b1;
            3'd6:       w_wr_lo = 1'b1;
            default: ;
          endcase
        end
        if (w_accept) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Start is ignored here, including mthi/mtlo.
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else begin
      if (w_accept) begin
        r_res_hi <= w_res_hi;
        r_res_lo <= w_res_lo;
      end
      if (w_commit) begin
        HI <= r_res_hi;
        LO <= r_res_lo;
      end else begin
        if (w_wr_hi) HI <= A;
        if (w_wr_lo) LO <= A;
      end
    end
  end

  assign Busy      = (r_state == S_RUN);
  assign Stall_req = Busy | (Start & w_is_muldiv);
  assign HILO_out  = RdSel ? LO : HI;

endmodule

// File: tb/tb_e_muldiv_unit.sv
module tb_e_muldiv_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        Clk, Rst, Start, RdSel;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Stall_req;
  logic [31:0] HI, LO, HILO_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi, m_lo;

  e_muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .RdSel(RdSel),
    .Busy(Busy), .HI(HI), .LO(LO), .HILO_out(HILO_out), .Stall_req(Stall_req)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic from the ISA rules.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] p;
    sa = $signed(a); sb = $signed(b);
    ua = {32'd0, a}; ub = {32'd0, b};
    hi = 32'd0; lo = 32'd0;
    case (op)
      3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
      3'd3: if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
            else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      3'd4: if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
            else begin uq = ua / ub; ur = ua % ub; hi = ur[31:0]; lo = uq[31:0]; end
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_hi"}, HI, m_hi);
    check({tag, "_lo"}, LO, m_lo);
  endtask

  // Issue a mul/div at the current cycle and follow it to commit. With
  // inject set, ignored ops (mtlo then mult) are driven in busy cycles 2 and 3.
  task automatic run_muldiv(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit inject);
    logic [31:0] eh, el;
    int n;
    ref_op(op, a, b, eh, el);
    n = (op <= 3'd2) ? MC : DC;
    Start = 1'b1; Op = op; A = a; B = b;
    #1;
    check("acc_stall", 32'(Stall_req), 32'd1);
    check("acc_busy", 32'(Busy), 32'd0);
    tick();
    Start = 1'b0; Op = 3'd0; A = $urandom; B = $urandom;
    for (int k = 1; k <= n; k++) begin
      #1;
      check("run_busy", 32'(Busy), 32'd1);
      check("run_stall", 32'(Stall_req), 32'd1);
      check_regs("run_hold");
      if (inject && n >= 4 && k == 2) begin Start = 1'b1; Op = 3'd6; A = 32'd0; end
      else if (inject && n >= 4 && k == 3) begin Start = 1'b1; Op = 3'd1; A = $urandom; B = $urandom; end
      else begin Start = 1'b0; Op = 3'd0; end
      tick();
    end
    Start = 1'b0; Op = 3'd0;
    m_hi = eh; m_lo = el;
    #1;
    check("done_busy", 32'(Busy), 32'd0);
    check("done_stall", 32'(Stall_req), 32'd0);
    check_regs("done");
    RdSel = 1'b0; #1; check("done_out_hi", HILO_out, m_hi);
    RdSel = 1'b1; #1; check("done_out_lo", HILO_out, m_lo);
    tick();
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
    Start = 1'b1; Op = op; A = a;
    #1;
    check("mt_stall", 32'(Stall_req), 32'd0);
    tick();
    Start = 1'b0; Op = 3'd0;
    if (op == 3'd5) m_hi = a; else m_lo = a;
    #1;
    check("mt_busy", 32'(Busy), 32'd0);
    check_regs("mt");
  endtask

  task automatic run_idle();
    Start = 1'($urandom_range(0, 1));
    Op    = Start ? (($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7) : 3'($urandom_range(0, 7));
    A = $urandom; B = $urandom;
    #1;
    check("idle_stall", 32'(Stall_req), 32'(Start && Op >= 3'd1 && Op <= 3'd4));
    tick();
    Start = 1'b0; Op = 3'd0;
    #1;
    check("idle_busy", 32'(Busy), 32'd0);
    check_regs("idle");
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int sel;
    Rst = 1'b1; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0; RdSel = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    #12;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_stall", 32'(Stall_req), 32'd0);
    check_regs("rst");
    check("rst_out", HILO_out, 32'd0);
    Rst = 1'b0;
    tick();

    // Directed steps from the plan.
    run_muldiv(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_muldiv(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_muldiv(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_muldiv(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_muldiv(3'd4, 32'd7, 32'd2, 1'b0);
    run_muldiv(3'd3, 32'd5, 32'd0, 1'b0);
    run_muldiv(3'd4, 32'h8000_0001, 32'd0, 1'b0);
    run_muldiv(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_mt(3'd5, 32'h1234_5678);
    run_mt(3'd6, 32'h9ABC_DEF0);
    RdSel = 1'b0; #1; check("mt_out_hi", HILO_out, 32'h1234_5678);
    RdSel = 1'b1; #1; check("mt_out_lo", HILO_out, 32'h9ABC_DEF0);
    tick();
    run_muldiv(3'd3, 32'd100, 32'd7, 1'b1);
    check("ign_lo", LO, 32'd14);
    check("ign_hi", HI, 32'd2);

    // Reset in busy cycle 3 of a mult; the pending result must never appear.
    Start = 1'b1; Op = 3'd1; A = 32'd3; B = 32'd4;
    tick();
    Start = 1'b0; Op = 3'd0;
    tick(); tick();
    #2 Rst = 1'b1;
    #1;
    check("arst_busy", 32'(Busy), 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    Rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    tick();
    for (int k = 0; k < MC + 2; k++) begin
      check("arst_quiet_busy", 32'(Busy), 32'd0);
      check_regs("arst_quiet");
      tick();
    end
    run_muldiv(3'd1, 32'd2, 32'd2, 1'b0);
    check("arst_after_lo", LO, 32'd4);

    // Randomized mix against the reference model.
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        op = 3'($urandom_range(1, 4));
        a = $urandom; b = $urandom;
        case ($urandom_range(0, 7))
          0: b = 32'd0;
          1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          2: b = 32'($urandom_range(1, 9));
          3: b = -32'($urandom_range(1, 9));
          default: ;
        endcase
        run_muldiv(op, a, b, 1'($urandom_range(0, 1)));
      end else if (sel <= 6) begin
        run_mt(3'($urandom_range(5, 6)), $urandom);
      end else begin
        run_idle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
